tick_pwm: RTL and testbench

TICK_PWM -- requirements
Module: tick_pwm

---
 rtl/tick_pwm_pkg.sv | 9 +
 rtl/tick_pwm_edge_tick.sv | 18 +
 rtl/tick_pwm.sv | 77 +++++++
 tb/tb_tick_pwm.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tick_pwm_pkg.sv
// tick_pwm_pkg: shared FSM state encoding and default width for tick_pwm.
package tick_pwm_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;
endpackage

// File: rtl/tick_pwm_edge_tick.sv
// edge_tick: registered one-clk pulse on each rising edge of div_clk.
module edge_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic div_clk,
    output logic tick
);
    logic div_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 1'b0;
            tick  <= 1'b0;
        end else begin
            div_q <= div_clk;
            tick  <= div_clk & ~div_q;
        end
    end
endmodule

// File: rtl/tick_pwm.sv
// tick_pwm: tick-driven PWM generator with shadowed period/duty config
// applied only at period boundaries, and a graceful stop on enable drop.
import tick_pwm_pkg::*;
module tick_pwm #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             cfg_ready,
    output logic             tick,
    output logic             pwm_out,
    output logic             period_done
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx, p_act, d_act, sh_p, sh_d, p_nx, d_nx;
    logic             pending, start, bnd, load, stop_end, accept;

    edge_tick u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_clk (div_clk),
        .tick    (tick)
    );

    always_comb begin
        start    = tick && state == IDLE && enable;
        bnd      = tick && state != IDLE && cnt == p_act;
        load     = pending && (start || bnd);
        p_nx     = load ? sh_p : p_act;
        d_nx     = load ? sh_d : d_act;
        cnt_nx   = (start || bnd) ? '0 : cnt + WIDTH'(1);
        stop_end = bnd && state == STOPPING && !enable;
        accept   = cfg_valid && !pending;
        state_nx = state == IDLE ? (start ? RUN : IDLE)
                 : enable        ? RUN
                 : stop_end      ? IDLE
                 :                 STOPPING;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
            pending     <= 1'b0;
            sh_p        <= '0;
            sh_d        <= '0;
            p_act       <= '0;
            d_act       <= '0;
        end else begin
            state       <= state_nx;
            period_done <= bnd;
            if (tick)
                cnt <= (state == IDLE || stop_end) ? '0 : cnt_nx;
            // Compare against post-boundary values so a new duty takes effect on the first tick of its period.
            if (start || (tick && state != IDLE))
                pwm_out <= !stop_end && (cnt_nx < d_nx);
            if (load) begin
                p_act <= sh_p;
                d_act <= sh_d;
            end
            if (accept) begin
                sh_p <= cfg_period;
                sh_d <= cfg_duty;
            end
            pending <= accept | (pending & ~load);
        end
    end

    assign cfg_ready = ~pending;
endmodule

// File: tb/tb_tick_pwm.sv
// tb_tick_pwm: directed + randomized checks of tick_pwm against a tick-level reference model.
module tb_tick_pwm;
    logic       clk = 1'b0, rst_n = 1'b0, div_clk = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_period = '0, cfg_duty = '0;
    logic       cfg_ready, tick, pwm_out, period_done;

    int compared = 0, mismatched = 0;
    int div_per = 6, dph = 0;
    // reference model: mode 0 idle, 1 running, 2 finishing last period
    int m_mode, m_pos, m_p, m_d, m_sp, m_sd;
    bit m_pend, m_tick, m_divq, m_pwm, m_pd;

    tick_pwm #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_clk     (div_clk),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_ready   (cfg_ready),
        .tick        (tick),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_mode = 0; m_pos = 0; m_p = 0; m_d = 0; m_sp = 0; m_sd = 0;
        m_pend = 0; m_tick = 0; m_divq = 0; m_pwm = 0; m_pd = 0;
    endtask

    task automatic check_all();
        chk("tick", tick, m_tick);
        chk("pwm_out", pwm_out, m_pwm);
        chk("period_done", period_done, m_pd);
        chk("cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic consume();
        m_p = m_sp; m_d = m_sd; m_pend = 0;
    endtask

    task automatic step();
        bit acc, t;
        int om;
        @(posedge clk);
        if (!rst_n) model_zero();
        else begin
            acc = cfg_valid && !m_pend;
            t = m_tick;
            m_tick = div_clk && !m_divq;
            m_divq = div_clk;
            m_pd = 0;
            om = m_mode;
            if (t) begin
                if (om == 0) begin
                    if (enable) begin
                        if (m_pend) consume();
                        m_mode = 1; m_pos = 0; m_pwm = (0 < m_d);
                    end
                end else begin
                    if (m_pos == m_p) begin
                        m_pd = 1; m_pos = 0;
                        if (m_pend) consume();
                    end else m_pos++;
                    if (m_pd && om == 2 && !enable) m_pwm = 0;
                    else m_pwm = m_pos < m_d;
                end
            end
            if (om == 1) m_mode = enable ? 1 : 2;
            if (om == 2) m_mode = enable ? 1 : (m_pd ? 0 : 2);
            if (m_mode == 0 && om == 2) m_pos = 0;
            if (acc) begin m_sp = cfg_period; m_sd = cfg_duty; m_pend = 1; end
        end
        #1 check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            div_clk = (dph % div_per) < (div_per / 2);
            dph++;
            step();
        end
    endtask

    task automatic cfg(input int p, input int d);
        cfg_period = 8'(p); cfg_duty = 8'(d); cfg_valid = 1'b1;
        run(1);
        cfg_valid = 1'b0;
    endtask

    task automatic async_rst();
        #2 rst_n = 1'b0;
        #1 model_zero();
        check_all();
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        model_zero();
        // reset held with all inputs toggling
        for (int i = 0; i < 6; i++) begin
            {div_clk, enable, cfg_valid} = 3'($urandom);
            cfg_period = 8'($urandom); cfg_duty = 8'($urandom);
            step();
        end
        {div_clk, enable, cfg_valid} = '0;
        rst_n = 1'b1;
        run(20);
        // basic P=3 D=2 waveform
        cfg(3, 2);
        enable = 1'b1;
        run(120);
        cfg(3, 0);
        run(80);
        cfg(3, 9);
        run(80);
        div_per = 2;
        cfg(255, 255);
        run(1100);
        // mid-period reload with a rejected second offer
        div_per = 6;
        cfg(7, 4);
        run(100);
        cfg(3, 1);
        cfg_valid = 1'b1; cfg_period = 8'd5; cfg_duty = 8'd5;
        run(20);
        cfg_valid = 1'b0;
        run(100);
        // graceful stop, then reassert before boundary
        cfg(7, 4);
        run(60);
        enable = 1'b0;
        run(80);
        enable = 1'b1;
        run(60);
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        run(60);
        async_rst();
        run(30);
        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            div_clk = 1'($urandom_range(0, 1));
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_period = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
            cfg_duty = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 499) == 0) async_rst();
            else step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
